// File: rtl/convertible_fifo_mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : convertible_fifo_mode_ctrl_pkg
//  Description : Shared state encoding and defaults for the convertible
//                FIFO/DMEM mode sequencer. The CPU-side status register map
//                also uses these definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
package convertible_fifo_mode_ctrl_pkg;

   localparam int STATE_W             = 3;
   localparam int DEFAULT_WDOG_CYCLES = 4096;

   // The numeric values are visible to software through state_o.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_RX    = 3'd1,
      ST_GRD_C = 3'd2,
      ST_CPU   = 3'd3,
      ST_GRD_F = 3'd4,
      ST_TX    = 3'd5
   } mode_state_e;

endpackage
`default_nettype wire

// File: rtl/convertible_fifo_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : convertible_fifo_mode_ctrl_if
//  Description : Status/control bundle between the mode sequencer, the
//                convertible buffer, the small input FIFO and the CPU.
//                master = the sequencer, slave = the surrounding datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface convertible_fifo_mode_ctrl_if
   import convertible_fifo_mode_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 16
);

   logic                 enable_i;
   logic                 eop_written_i;
   logic                 fifo_full_i;
   logic                 fifo_empty_i;
   logic                 cpu_done_i;
   logic                 cpu_mem_busy_i;
   logic                 switch_o;
   logic                 rx_enable_o;
   logic                 tx_enable_o;
   logic                 cpu_stall_o;
   logic                 cpu_start_o;
   logic [STATE_W-1:0]   state_o;
   logic [CNT_WIDTH-1:0] pkt_count_o;
   logic                 wdog_err_o;

   modport master (
      input  enable_i, eop_written_i, fifo_full_i, fifo_empty_i,
             cpu_done_i, cpu_mem_busy_i,
      output switch_o, rx_enable_o, tx_enable_o, cpu_stall_o, cpu_start_o,
             state_o, pkt_count_o, wdog_err_o
   );

   modport slave (
      output enable_i, eop_written_i, fifo_full_i, fifo_empty_i,
             cpu_done_i, cpu_mem_busy_i,
      input  switch_o, rx_enable_o, tx_enable_o, cpu_stall_o, cpu_start_o,
             state_o, pkt_count_o, wdog_err_o
   );

endinterface
`default_nettype wire

// File: rtl/convertible_fifo_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : convertible_fifo_mode_ctrl
//  Description : Time-shares the convertible buffer between the packet
//                datapath (FIFO mode) and the CPU (DMEM mode), one packet at
//                a time: receive -> guard -> CPU -> guard -> drain.
//                Optional macro MODE_CTRL_WATCHDOG_EN bounds the CPU phase
//                to WDOG_CYCLES and raises a sticky wdog_err_o on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module convertible_fifo_mode_ctrl
   import convertible_fifo_mode_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int WDOG_CYCLES = DEFAULT_WDOG_CYCLES
) (
   input  logic                        clock,
   input  logic                        reset_n,
   convertible_fifo_mode_ctrl_if.master bus
);

   mode_state_e          r_state;
   mode_state_e          w_state_nxt;
   logic                 r_switch;
   logic                 r_stall;
   logic                 r_start;
   logic [CNT_WIDTH-1:0] r_pkt_count;
   logic                 w_wdog_hit;
   logic                 w_wdog_err;

   // Next-state decode; the watchdog can stand in for cpu_done but the
   // exit still waits for any in-flight load/store to retire.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.enable_i)      w_state_nxt = ST_RX;
         ST_RX:    if (bus.eop_written_i) w_state_nxt = ST_GRD_C;
         ST_GRD_C:                        w_state_nxt = ST_CPU;
         ST_CPU:   if ((bus.cpu_done_i || w_wdog_hit) && !bus.cpu_mem_busy_i)
                                          w_state_nxt = ST_GRD_F;
         ST_GRD_F:                        w_state_nxt = ST_TX;
         ST_TX:    if (bus.fifo_empty_i)  w_state_nxt = ST_IDLE;
         default:                         w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Mode/stall/start flops decoded from the next state so they change on
   // the same edge as the state itself.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_switch    <= 1'b1;
         r_stall     <= 1'b1;
         r_start     <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         r_switch <= (w_state_nxt != ST_CPU);
         r_stall  <= (w_state_nxt != ST_CPU);
         r_start  <= (w_state_nxt == ST_CPU) && (r_state != ST_CPU);
         if ((r_state == ST_TX) && bus.fifo_empty_i)
            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      end
   end

`ifdef MODE_CTRL_WATCHDOG_EN
   localparam int              WDOG_W    = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] r_wdog_cnt;
   logic              r_wdog_err;

   // The count is zero on the first CPU cycle, so hitting WDOG_LAST means
   // the CPU has had exactly WDOG_CYCLES cycles.
   assign w_wdog_hit = (r_state == ST_CPU) && (r_wdog_cnt >= WDOG_LAST) &&
                       !bus.cpu_done_i;
   assign w_wdog_err = r_wdog_err;

   // Saturating CPU-phase cycle counter and sticky timeout flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wdog_cnt <= '0;
         r_wdog_err <= 1'b0;
      end else begin
         if (r_state != ST_CPU)
            r_wdog_cnt <= '0;
         else if (r_wdog_cnt < WDOG_LAST)
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
         if (w_wdog_hit)
            r_wdog_err <= 1'b1;
      end
   end
`else
   assign w_wdog_hit = 1'b0;
   assign w_wdog_err = 1'b0;
`endif

   // Buffer read/write permits stay combinational so a full/empty change
   // gates the very next transfer.
   assign bus.rx_enable_o = (r_state == ST_RX) && !bus.fifo_full_i;
   assign bus.tx_enable_o = (r_state == ST_TX) && !bus.fifo_empty_i;

   assign bus.switch_o    = r_switch;
   assign bus.cpu_stall_o = r_stall;
   assign bus.cpu_start_o = r_start;
   assign bus.state_o     = r_state;
   assign bus.pkt_count_o = r_pkt_count;
   assign bus.wdog_err_o  = w_wdog_err;

endmodule
`default_nettype wire

// File: tb/tb_convertible_fifo_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_convertible_fifo_mode_ctrl
//  Description : Self-checking bench for the convertible FIFO mode sequencer.
//                Expected packet counts are queued when a packet is launched
//                and compared when the sequencer returns to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_convertible_fifo_mode_ctrl;
   import convertible_fifo_mode_ctrl_pkg::*;

   localparam int CNT_W = 16;
   localparam int WDOG  = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   logic [CNT_W-1:0] model_count = '0;
   logic [CNT_W-1:0] sb_q[$];

   convertible_fifo_mode_ctrl_if #(.CNT_WIDTH(CNT_W)) bus ();

   convertible_fifo_mode_ctrl #(
      .CNT_WIDTH   (CNT_W),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic idle_inputs();
      bus.enable_i       = 1'b0;
      bus.eop_written_i  = 1'b0;
      bus.fifo_full_i    = 1'b0;
      bus.fifo_empty_i   = 1'b1;
      bus.cpu_done_i     = 1'b0;
      bus.cpu_mem_busy_i = 1'b0;
   endtask

   // From IDLE: request a packet and queue its expected drained count.
   task automatic start_packet();
      model_count = model_count + 1'b1;
      sb_q.push_back(model_count);
      bus.enable_i = 1'b1;
      @(negedge clock);
      bus.enable_i = 1'b0;
      checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL idle_to_rx: state_o=%0d expected 1", bus.state_o); end
      checks++; if (bus.switch_o !== 1'b1 || bus.cpu_stall_o !== 1'b1) begin errors++; $display("FAIL rx_mode: switch_o=%b cpu_stall_o=%b expected 1 1", bus.switch_o, bus.cpu_stall_o); end
   endtask

   // Blocked cycles first, then words; eop on the last word or with full.
   task automatic rx_phase(input int nwords, input int full_cycles, input bit eop_with_full);
      for (int i = 0; i < full_cycles; i++) begin
         bus.fifo_full_i = 1'b1;
         #1;
         checks++; if (bus.rx_enable_o !== 1'b0) begin errors++; $display("FAIL rx_full_block: rx_enable_o=%b expected 0", bus.rx_enable_o); end
         @(negedge clock);
         checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL rx_full_hold: state_o=%0d expected 1", bus.state_o); end
      end
      for (int i = 0; i < nwords; i++) begin
         bus.fifo_full_i   = 1'b0;
         bus.eop_written_i = (i == nwords - 1) && !eop_with_full;
         #1;
         checks++; if (bus.rx_enable_o !== 1'b1) begin errors++; $display("FAIL rx_enable: rx_enable_o=%b expected 1", bus.rx_enable_o); end
         @(negedge clock);
         if (i != nwords - 1 || eop_with_full) begin
            checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL rx_stay: state_o=%0d expected 1", bus.state_o); end
         end
      end
      if (eop_with_full) begin
         bus.fifo_full_i   = 1'b1;
         bus.eop_written_i = 1'b1;
         #1;
         checks++; if (bus.rx_enable_o !== 1'b0) begin errors++; $display("FAIL rx_eop_full: rx_enable_o=%b expected 0", bus.rx_enable_o); end
         @(negedge clock);
      end
      bus.eop_written_i = 1'b0;
      bus.fifo_full_i   = 1'b0;
      bus.fifo_empty_i  = 1'b0;
      #1;
      checks++; if (bus.state_o !== 3'd2 || bus.rx_enable_o !== 1'b0 || bus.tx_enable_o !== 1'b0 || bus.switch_o !== 1'b1) begin errors++; $display("FAIL guard_c: state_o=%0d rx=%b tx=%b switch_o=%b expected 2 0 0 1", bus.state_o, bus.rx_enable_o, bus.tx_enable_o, bus.switch_o); end
      @(negedge clock);
      checks++; if (bus.state_o !== 3'd3 || bus.switch_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin errors++; $display("FAIL cpu_entry: state_o=%0d switch_o=%b stall=%b expected 3 0 0", bus.state_o, bus.switch_o, bus.cpu_stall_o); end
      checks++; if (bus.cpu_start_o !== 1'b1) begin errors++; $display("FAIL cpu_start: cpu_start_o=%b expected 1", bus.cpu_start_o); end
   endtask

   // In CPU: done held with busy for busy_cycles, then busy drops; ends at
   // the first TX cycle with one word available.
   task automatic cpu_phase(input int busy_cycles);
      for (int i = 0; i < busy_cycles; i++) begin
         bus.cpu_done_i     = 1'b1;
         bus.cpu_mem_busy_i = 1'b1;
         @(negedge clock);
         checks++; if (bus.state_o !== 3'd3 || bus.cpu_stall_o !== 1'b0 || bus.cpu_start_o !== 1'b0) begin errors++; $display("FAIL cpu_busy_wait: state_o=%0d stall=%b start=%b expected 3 0 0", bus.state_o, bus.cpu_stall_o, bus.cpu_start_o); end
      end
      bus.cpu_done_i     = 1'b1;
      bus.cpu_mem_busy_i = 1'b0;
      @(negedge clock);
      bus.cpu_done_i = 1'b0;
      #1;
      checks++; if (bus.state_o !== 3'd4 || bus.cpu_stall_o !== 1'b1 || bus.switch_o !== 1'b1 || bus.tx_enable_o !== 1'b0) begin errors++; $display("FAIL guard_f: state_o=%0d stall=%b switch_o=%b tx=%b expected 4 1 1 0", bus.state_o, bus.cpu_stall_o, bus.switch_o, bus.tx_enable_o); end
      @(negedge clock);
      checks++; if (bus.state_o !== 3'd5 || bus.tx_enable_o !== 1'b1) begin errors++; $display("FAIL tx_entry: state_o=%0d tx=%b expected 5 1", bus.state_o, bus.tx_enable_o); end
   endtask

   // In TX (first word already offered): drain and score the packet count.
   task automatic tx_phase(input int nwords);
      logic [CNT_W-1:0] exp_cnt;
      bus.cpu_done_i = 1'b1;
      for (int i = 1; i < nwords; i++) begin
         @(negedge clock);
         checks++; if (bus.state_o !== 3'd5 || bus.tx_enable_o !== 1'b1) begin errors++; $display("FAIL tx_drain: state_o=%0d tx=%b expected 5 1", bus.state_o, bus.tx_enable_o); end
      end
      bus.fifo_empty_i = 1'b1;
      #1;
      checks++; if (bus.tx_enable_o !== 1'b0) begin errors++; $display("FAIL tx_empty: tx_enable_o=%b expected 0", bus.tx_enable_o); end
      @(negedge clock);
      bus.cpu_done_i = 1'b0;
      checks++; if (bus.state_o !== 3'd0 || bus.switch_o !== 1'b1 || bus.cpu_stall_o !== 1'b1) begin errors++; $display("FAIL tx_to_idle: state_o=%0d switch_o=%b stall=%b expected 0 1 1", bus.state_o, bus.switch_o, bus.cpu_stall_o); end
      checks++;
      if (sb_q.size() == 0) begin
         errors++; $display("FAIL pkt_count: no expected count queued, got %0d", bus.pkt_count_o);
      end else begin
         exp_cnt = sb_q.pop_front();
         if (bus.pkt_count_o !== exp_cnt) begin errors++; $display("FAIL pkt_count: pkt_count_o=%0d expected %0d", bus.pkt_count_o, exp_cnt); end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (bus.state_o !== 3'd0 || bus.switch_o !== 1'b1 || bus.cpu_stall_o !== 1'b1 || bus.cpu_start_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl: state=%0d switch=%b stall=%b start=%b expected 0 1 1 0", bus.state_o, bus.switch_o, bus.cpu_stall_o, bus.cpu_start_o); end
      checks++; if (bus.rx_enable_o !== 1'b0 || bus.tx_enable_o !== 1'b0 || bus.pkt_count_o !== '0 || bus.wdog_err_o !== 1'b0) begin errors++; $display("FAIL reset_data: rx=%b tx=%b cnt=%0d wdog=%b expected 0 0 0 0", bus.rx_enable_o, bus.tx_enable_o, bus.pkt_count_o, bus.wdog_err_o); end
      reset_n = 1'b1;
      @(negedge clock);
      checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL idle_hold: state_o=%0d expected 0", bus.state_o); end
   endtask

   task automatic test_ignored();
      bus.eop_written_i = 1'b1;
      bus.cpu_done_i    = 1'b1;
      bus.fifo_empty_i  = 1'b0;
      #1;
      checks++; if (bus.rx_enable_o !== 1'b0 || bus.tx_enable_o !== 1'b0) begin errors++; $display("FAIL idle_enables: rx=%b tx=%b expected 0 0", bus.rx_enable_o, bus.tx_enable_o); end
      @(negedge clock);
      checks++; if (bus.state_o !== 3'd0 || bus.cpu_start_o !== 1'b0) begin errors++; $display("FAIL idle_ignore: state_o=%0d start=%b expected 0 0", bus.state_o, bus.cpu_start_o); end
      idle_inputs();
   endtask

   task automatic test_basic_packet();
      start_packet();
      rx_phase(3, 0, 1'b0);
      cpu_phase(3);
      tx_phase(3);
   endtask

   task automatic test_back_to_back();
      start_packet();
      rx_phase(1, 0, 1'b0);
      cpu_phase(0);
      tx_phase(1);
      start_packet();
      rx_phase(4, 0, 1'b0);
      cpu_phase(1);
      tx_phase(2);
   endtask

   task automatic test_rx_full();
      start_packet();
      rx_phase(2, 4, 1'b1);
      cpu_phase(0);
      tx_phase(1);
   endtask

   task automatic test_cpu_phase_limit();
      int n;
      start_packet();
      rx_phase(1, 0, 1'b0);
      checks++; if (bus.wdog_err_o !== 1'b0) begin errors++; $display("FAIL wdog_pre: wdog_err_o=%b expected 0", bus.wdog_err_o); end
      bus.cpu_done_i     = 1'b0;
      bus.cpu_mem_busy_i = 1'b0;
`ifdef MODE_CTRL_WATCHDOG_EN
      n = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (bus.state_o != 3'd3) break;
         n++;
      end
      checks++; if (n != WDOG) begin errors++; $display("FAIL wdog_cycles: cpu cycles=%0d expected %0d", n, WDOG); end
      checks++; if (bus.state_o !== 3'd4 || bus.cpu_stall_o !== 1'b1 || bus.wdog_err_o !== 1'b1) begin errors++; $display("FAIL wdog_exit: state=%0d stall=%b wdog=%b expected 4 1 1", bus.state_o, bus.cpu_stall_o, bus.wdog_err_o); end
      @(negedge clock);
      checks++; if (bus.state_o !== 3'd5) begin errors++; $display("FAIL wdog_tx: state_o=%0d expected 5", bus.state_o); end
      tx_phase(1);
      start_packet();
      rx_phase(1, 0, 1'b0);
      cpu_phase(0);
      tx_phase(1);
      checks++; if (bus.wdog_err_o !== 1'b1) begin errors++; $display("FAIL wdog_sticky: wdog_err_o=%b expected 1", bus.wdog_err_o); end
`else
      n = 0;
      for (int k = 0; k < 2 * WDOG; k++) begin
         @(negedge clock);
         if (bus.state_o == 3'd3) n++;
      end
      checks++; if (n != 2 * WDOG || bus.wdog_err_o !== 1'b0) begin errors++; $display("FAIL cpu_unbounded: cpu cycles=%0d wdog=%b expected %0d 0", n, bus.wdog_err_o, 2 * WDOG); end
      cpu_phase(0);
      tx_phase(1);
`endif
   endtask

   task automatic test_reset_mid_cpu();
      start_packet();
      rx_phase(2, 0, 1'b0);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (bus.state_o !== 3'd0 || bus.switch_o !== 1'b1 || bus.cpu_stall_o !== 1'b1 || bus.pkt_count_o !== '0) begin errors++; $display("FAIL async_reset: state=%0d switch=%b stall=%b cnt=%0d expected 0 1 1 0", bus.state_o, bus.switch_o, bus.cpu_stall_o, bus.pkt_count_o); end
      sb_q.delete();
      model_count = '0;
      idle_inputs();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      start_packet();
      rx_phase(1, 0, 1'b0);
      cpu_phase(0);
      tx_phase(1);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ignored();
      test_basic_packet();
      test_back_to_back();
      test_rx_full();
      test_cpu_phase_limit();
      test_reset_mid_cpu();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/convertible_fifo_mode_ctrl.md
# convertible_fifo_mode_ctrl

Sequencer that owns the `switch` input of the convertible FIFO/DMEM memory and time-shares it between the NetFPGA datapath and the pipelined CPU. It runs one packet at a time through a fixed cycle: receive into the buffer in FIFO mode, hand the buffer to the CPU in DMEM mode, then drain it to the output in FIFO mode. It sits between the small input FIFO, the convertible buffer, and the CPU stall/start controls.

## Interface
Parameters:
- CNT_WIDTH, 16, width of the processed-packet counter
- WDOG_CYCLES, 4096, CPU-phase cycle limit (used only with the watchdog compiled in)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- enable_i  in  1  allow a new packet cycle to start; sampled only in IDLE
- eop_written_i  in  1  one-cycle pulse from the buffer: last word of the packet written
- fifo_full_i  in  1  buffer full
- fifo_empty_i  in  1  buffer empty (head == tail)
- cpu_done_i  in  1  CPU finished processing (level, held until stalled)
- cpu_mem_busy_i  in  1  CPU load/store in flight in the MEM stage
- switch_o  out  1  1 = FIFO mode, 0 = CPU/DMEM mode
- rx_enable_o  out  1  permit small-FIFO reads into the buffer
- tx_enable_o  out  1  permit buffer reads toward the output
- cpu_stall_o  out  1  hold the CPU pipeline
- cpu_start_o  out  1  one-cycle pulse on CPU-phase entry
- state_o  out  3  current FSM state encoding
- pkt_count_o  out  CNT_WIDTH  packets fully drained, wraps modulo 2^CNT_WIDTH
- wdog_err_o  out  1  sticky watchdog flag

## Operation
- States: IDLE=0, RX=1, GRD_C=2, CPU=3, GRD_F=4, TX=5.
- IDLE: switch_o=1, stall=1. enable_i=1 moves to RX.
- RX: rx_enable_o = (state==RX) && !fifo_full_i. This is combinational gating; while full, the FSM stays in RX with reads blocked. An eop_written_i pulse moves to GRD_C. If eop and full occur in the same cycle, eop wins.
- GRD_C: one dead cycle with rx and tx both 0, letting the last buffer write retire. switch_o drops to 0 on the exit edge. Next state is CPU.
- CPU: switch_o=0, cpu_stall_o=0, cpu_start_o high for the first CPU cycle only. The FSM exits to GRD_F when cpu_done_i=1 && cpu_mem_busy_i=0. cpu_done with busy high waits.
- GRD_F: cpu_stall_o=1, switch_o=1, no rx/tx. Next state is TX.
- TX: tx_enable_o = !fifo_empty_i. When fifo_empty_i=1: pkt_count_o increments and the FSM returns to IDLE.
- enable_i deassertion outside IDLE has no effect; the current packet completes.
- Counter arithmetic is unsigned modulo 2^CNT_WIDTH. The watchdog counter, when present, saturates.

## Timing
- Reset (asynchronous, immediate) values: state=IDLE, switch_o=1, rx/tx_enable_o=0, cpu_stall_o=1, cpu_start_o=0, pkt_count_o=0, wdog_err_o=0.
- All outputs except rx_enable_o and tx_enable_o are registered (state-decoded flops). rx/tx enables are state AND one combinational status term.
- Latencies:
  - IDLE→RX: 1 cycle after enable_i is sampled.
  - eop_written_i to switch_o=0: 2 edges (RX→GRD_C→CPU).
  - cpu_done to stall=1: 1 edge.
  - stall=1 to tx_enable: 1 edge.
- Minimum packet cycle with immediate done and a 1-word drain: 6 clocks.
- An eop pulse outside RX is ignored. cpu_done outside CPU is ignored.
- Reset asserted mid-packet returns to IDLE in FIFO mode with the CPU stalled; buffer contents are not cleared by this block.

## Configuration
- MODE_CTRL_WATCHDOG_EN defined:
  - A counter clears on CPU entry and increments each CPU cycle.
  - Reaching WDOG_CYCLES with no done forces GRD_F (still waiting for cpu_mem_busy_i=0) and sets wdog_err_o, which is sticky until reset.
- Undefined: no counter, wdog_err_o tied 0, and the CPU phase is unbounded.

## Structure
- Shared package holds the state enum/localparams (IDLE..TX, 3-bit) and the default WDOG_CYCLES constant, reused by the CPU-side status register map.
- Single module with no sub-module. The watchdog counter stays inline under the macro.

## Test plan
- Reset release, enable_i=1, 3-word packet with eop on word 3 → RX→GRD_C→CPU; switch_o=0 exactly 2 clocks after eop; cpu_start_o high 1 cycle.
- CPU phase: assert cpu_done_i with cpu_mem_busy_i=1 for 3 cycles, then busy=0 → stall rises 1 clock after busy falls; switch_o=1 the same edge.
- TX drain: 3 words, fifo_empty_i rises → tx_enable_o low, pkt_count_o=1, state_o=0; repeat 2 more packets → pkt_count_o=3.
- fifo_full_i=1 in RX for 4 cycles → rx_enable_o=0 those cycles, state stays 1; eop together with full → GRD_C.
- Reset_n pulsed low while in CPU → immediate switch_o=1, cpu_stall_o=1, pkt_count_o=0, state_o=0.
- With MODE_CTRL_WATCHDOG_EN and WDOG_CYCLES=16, no cpu_done → GRD_F after 16 CPU cycles and wdog_err_o=1 remains after the next packet.
